// File: rtl/slice_cfg_pkg.sv
// slice_cfg_pkg
// Shared definitions for slice configuration loading.
// - Size derivation functions: CFG_SIZE, MUX_LVLS, TOTAL_BITS, NUM_WORDS.
// - Loader state enum.
// - Flat image field offsets. The image is LSB first:
//   {config_use_cc, inter_lut_mux_config, luts_config}.
//   The bitstream generator uses the same offsets.
package slice_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_t;

    // Bits per LUT config half: 2**S_XX_BASE truth-table bits plus one mode bit.
    function automatic int cfg_size(input int s_xx_base);
        return (1 << s_xx_base) + 1;
    endfunction

    function automatic int mux_lvls(input int num_luts);
        return $clog2(num_luts);
    endfunction

    function automatic int total_bits(input int s_xx_base, input int num_luts);
        return 2 * cfg_size(s_xx_base) * num_luts + mux_lvls(num_luts) + 1;
    endfunction

    function automatic int num_words(input int tot_bits, input int word_w);
        return (tot_bits + word_w - 1) / word_w;
    endfunction

    // The LUT field starts at bit 0 of the flat image.
    function automatic int lut_field_ofs();
        return 0;
    endfunction

    function automatic int mux_field_ofs(input int s_xx_base, input int num_luts);
        return lut_field_ofs() + 2 * cfg_size(s_xx_base) * num_luts;
    endfunction

    function automatic int use_cc_field_ofs(input int s_xx_base, input int num_luts);
        return mux_field_ofs(s_xx_base, num_luts) + mux_lvls(num_luts);
    endfunction

endpackage

// File: rtl/cfg_word_shadow.sv
// cfg_word_shadow
// Shadow register that is written one word at a time.
// Word n, bit b lands on flat bit n*WORD_W + b.
// Ports:
//   cclk, rst : config clock; asynchronous active-high reset (clears the image)
//   wr_en     : write wr_data into the word selected by wr_idx
//   wr_idx    : word index
//   wr_data   : config word
//   shadow    : assembled TOTAL_BITS-wide image
module cfg_word_shadow #(
    parameter int TOTAL_BITS = 139,
    parameter int WORD_W     = 8,
    parameter int NUM_WORDS  = 18,
    parameter int IDX_W      = 5
) (
    input  logic                  cclk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WORD_W-1:0]     wr_data,
    output logic [TOTAL_BITS-1:0] shadow
);

    logic [NUM_WORDS-1:0]  word_sel;
    logic [TOTAL_BITS-1:0] shadow_next;

    for (genvar n = 0; n < NUM_WORDS; n++) begin : g_sel
        assign word_sel[n] = wr_en && (wr_idx == IDX_W'(n));
    end

    // The loop covers only the real image bits. Last-word bits at or above
    // TOTAL_BITS have no destination, so they are dropped here.
    for (genvar i = 0; i < TOTAL_BITS; i++) begin : g_bit
        assign shadow_next[i] = word_sel[i / WORD_W] ? wr_data[i % WORD_W] : shadow[i];
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_next;
        end
    end

endmodule

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader
// Configuration sequencer for one slicel.
// It assembles a ready/valid word stream into a shadow image. After the last
// word it pulses cen for one cclk cycle, so the slice captures a coherent image.
// Ports:
//   cclk, rst                 : config clock; asynchronous active-high reset
//   start, abort              : begin a load; cancel a load in progress
//   cfg_data/valid/ready      : config word stream
//   luts_config_out           : to slice luts_config_in
//   inter_lut_mux_config_out  : to slice inter_lut_mux_config
//   config_use_cc_out         : to slice config_use_cc
//   cen                       : slice capture enable, high in COMMIT
//   busy                      : high in LOAD or COMMIT
//   done                      : one-cycle pulse after a commit
//   word_count                : words accepted in the current load
module slicel_cfg_loader
    import slice_cfg_pkg::*;
#(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int WORD_W    = 8,
    localparam int CFG_SIZE   = cfg_size(S_XX_BASE),
    localparam int MUX_LVLS   = mux_lvls(NUM_LUTS),
    localparam int LUT_BITS   = 2 * CFG_SIZE * NUM_LUTS,
    localparam int TOTAL_BITS = total_bits(S_XX_BASE, NUM_LUTS),
    localparam int NUM_WORDS  = num_words(TOTAL_BITS, WORD_W),
    localparam int CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [LUT_BITS-1:0] luts_config_out,
    output logic [MUX_LVLS-1:0] inter_lut_mux_config_out,
    output logic                config_use_cc_out,
    output logic                cen,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    word_count
);

    localparam int LUT_OFS    = lut_field_ofs();
    localparam int MUX_OFS    = mux_field_ofs(S_XX_BASE, NUM_LUTS);
    localparam int USE_CC_OFS = use_cc_field_ofs(S_XX_BASE, NUM_LUTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    cfg_state_t            state;
    cfg_state_t            next_state;
    logic                  count_clear;
    logic                  accept;
    logic [TOTAL_BITS-1:0] shadow;

    // A word is taken only in LOAD. An abort on the same cycle discards the
    // word, so an abort that lands on the final word cannot reach COMMIT.
    assign accept = (state == LOAD) && cfg_valid && !abort;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        count_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state  = LOAD;
                    count_clear = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (cfg_valid && (word_count == LAST_IDX)) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (count_clear) begin
            word_count <= '0;
        end else if (accept) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    // COMMIT always lasts one cycle, so done simply follows it by one cycle.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == COMMIT);
        end
    end

    // These outputs are decoded from state only. Reset clears state, so cen
    // drops without waiting for a clock edge.
    assign cfg_ready = (state == LOAD);
    assign cen       = (state == COMMIT);
    assign busy      = (state != IDLE);

    cfg_word_shadow #(
        .TOTAL_BITS(TOTAL_BITS),
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (CNT_W)
    ) u_shadow (
        .cclk   (cclk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_idx (word_count),
        .wr_data(cfg_data),
        .shadow (shadow)
    );

    assign luts_config_out          = shadow[LUT_OFS +: LUT_BITS];
    assign inter_lut_mux_config_out = shadow[MUX_OFS +: MUX_LVLS];
    assign config_use_cc_out        = shadow[USE_CC_OFS];

endmodule
